// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : RV32I fetch with imem req/ack, decode valid/ready and redirects
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            misaligned_err_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] redirect_tgt;
    assign redirect_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            instr_q <= NOP_INSTR;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        req_d   = req_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        err_d   = err_q;

        case (state_q)
            S_FETCH: begin
                // A redirect here still issues the old-pc request; it is squashed on return.
                addr_d  = pc_q;
                req_d   = 1'b1;
                state_d = S_WAIT;
                if (redirect_valid_i) begin
                    kill_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_ack_i) begin
                    req_d = 1'b0;
                    if (kill_q || redirect_valid_i) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        instr_d = imem_rdata_i;
                        ipc_d   = addr_q;
                        valid_d = 1'b1;
                        pc_d    = addr_q + PC_STEP;
                        state_d = S_HOLD;
                    end
                end else if (redirect_valid_i) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (instr_ready_i || redirect_valid_i) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (redirect_valid_i) begin
            pc_d = redirect_tgt;
            if (redirect_pc_i[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
        end
    end

    assign imem_req_o       = req_q;
    assign imem_addr_o      = addr_q;
    assign instr_o          = instr_q;
    assign instr_pc_o       = ipc_q;
    assign instr_valid_o    = valid_q;
    assign misaligned_err_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : scoreboard bench for fetch_stage (directed + random)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        misaligned_err_o;

    fetch_stage #(
        .XLEN      (32),
        .RESET_PC  (32'h0),
        .NOP_INSTR (NOP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ack_i       (imem_ack_i),
        .imem_rdata_i     (imem_rdata_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .misaligned_err_o (misaligned_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_deliv = 0;
    int          cyc = 0;
    bit          err_model = 1'b0;
    bit          err_next = 1'b0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;

    // Program image: every word address holds a distinct pseudo-random instruction.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Expected architectural stream: sequential words from the latest start point.
    task automatic load_stream(input logic [31:0] start);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            e.pc  = start + 32'(4 * i);
            e.ins = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    // ack_mode: 0 never ack, 1 ack any pending request, 2 ack pending request at random
    task automatic tick(input int ack_mode, input bit rd, input logic [31:0] rpc, input bit rdy);
        bit do_ack;
        do_ack = (imem_req_o === 1'b1) &&
                 (ack_mode == 1 || (ack_mode == 2 && $urandom_range(0, 1) == 1));
        imem_ack_i       = do_ack;
        imem_rdata_i     = do_ack ? (ovr_en ? ovr_data : mem_word(imem_addr_o)) : $urandom;
        redirect_valid_i = rd;
        redirect_pc_i    = rd ? rpc : $urandom;
        instr_ready_i    = rdy;
        if (rd) begin
            load_stream({rpc[31:2], 2'b00});
            if (rpc[1:0] != 2'b00) err_next = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        err_model        = 1'b0;
        err_next         = 1'b0;
        imem_ack_i       = 1'b0;
        redirect_valid_i = 1'b0;
        instr_ready_i    = 1'b0;
        load_stream(32'h0);
        #1;
        chk("rst_req",   imem_req_o,       32'h0);
        chk("rst_addr",  imem_addr_o,      32'h0);
        chk("rst_instr", instr_o,          NOP);
        chk("rst_ipc",   instr_pc_o,       32'h0);
        chk("rst_valid", instr_valid_o,    32'h0);
        chk("rst_err",   misaligned_err_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_req(input string name, input logic [31:0] a, input bit rdy);
        int n = 0;
        while (imem_req_o !== 1'b1 && n < 20) begin
            tick(0, 1'b0, 32'h0, rdy);
            n++;
        end
        if (imem_req_o !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout waiting for imem_req, got %b want 1", name, imem_req_o);
        end else begin
            chk(name, imem_addr_o, a);
        end
    endtask

    // Request already pending: one idle cycle, then ack.
    task automatic ack_after_one(input bit rdy);
        tick(0, 1'b0, 32'h0, rdy);
        tick(1, 1'b0, 32'h0, rdy);
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        exp_t        e;
        bit          prev_req;
        logic [31:0] prev_addr;
        prev_req  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                prev_req = 1'b0;
            end else begin
                if (instr_valid_o !== 1'b1) chk("idle_nop", instr_o, NOP);
                if (imem_req_o === 1'b1) begin
                    chk("addr_align", {30'h0, imem_addr_o[1:0]}, 32'h0);
                    if (prev_req) chk("addr_stable", imem_addr_o, prev_addr);
                end
                if (instr_valid_o === 1'b1 && instr_ready_i && !redirect_valid_i) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL deliver: unexpected instr at pc %h, want none", instr_pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("deliver_pc", instr_pc_o, e.pc);
                        chk("deliver_instr", instr_o, e.ins);
                        n_deliv++;
                    end
                end
                chk("err_sticky", misaligned_err_o, {31'h0, err_model});
                err_model = err_next;
                prev_req  = (imem_req_o === 1'b1);
                prev_addr = imem_addr_o;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          t_prev;
        int          d0;
        bit          rd;
        logic [31:0] tgt;
        t_prev = 0;
        #6;
        do_reset();

        // Sequential fetch, ack one cycle after req, decode always ready
        for (int k = 0; k < 3; k++) begin
            wait_req($sformatf("t1_addr%0d", k), 32'(4 * k), 1'b1);
            ack_after_one(1'b1);
            chk("t1_valid", instr_valid_o, 32'h1);
            chk("t1_ipc", instr_pc_o, 32'(4 * k));
            if (k > 0) chk("t1_period", 32'(cyc - t_prev), 32'd4);
            t_prev = cyc;
        end

        // Decode back-pressure at pc 4
        do_reset();
        wait_req("t2_addr0", 32'h0, 1'b1);
        ack_after_one(1'b1);
        wait_req("t2_addr4", 32'h4, 1'b1);
        ack_after_one(1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("t2_valid", instr_valid_o, 32'h1);
            chk("t2_instr", instr_o, mem_word(32'h4));
            chk("t2_ipc", instr_pc_o, 32'h4);
            chk("t2_noreq", imem_req_o, 32'h0);
            tick(0, 1'b0, 32'h0, 1'b0);
        end
        tick(0, 1'b0, 32'h0, 1'b1);
        wait_req("t2_addr8", 32'h8, 1'b1);

        // Redirect while waiting; late ack is dropped
        tick(0, 1'b0, 32'h0, 1'b1);
        tick(0, 1'b1, 32'h100, 1'b1);
        tick(0, 1'b0, 32'h0, 1'b1);
        tick(0, 1'b0, 32'h0, 1'b1);
        ovr_en   = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        tick(1, 1'b0, 32'h0, 1'b1);
        ovr_en   = 1'b0;
        chk("t3_novalid", instr_valid_o, 32'h0);
        wait_req("t3_addr100", 32'h100, 1'b1);

        // Redirect coincident with ack
        tick(1, 1'b1, 32'h200, 1'b1);
        chk("t4_novalid", instr_valid_o, 32'h0);
        wait_req("t4_addr200", 32'h200, 1'b1);
        ack_after_one(1'b1);
        chk("t4_ipc", instr_pc_o, 32'h200);

        // Redirect in HOLD with ready high
        wait_req("t5_addr204", 32'h204, 1'b1);
        ack_after_one(1'b0);
        chk("t5_valid", instr_valid_o, 32'h1);
        tick(0, 1'b1, 32'h300, 1'b1);
        chk("t5_drop", instr_valid_o, 32'h0);
        chk("t5_nop", instr_o, NOP);
        wait_req("t5_addr300", 32'h300, 1'b1);

        // Misaligned redirect, wrap, FETCH-state redirect
        tick(0, 1'b1, 32'h302, 1'b1);
        chk("t6_err", misaligned_err_o, 32'h1);
        tick(1, 1'b0, 32'h0, 1'b1);
        wait_req("t6_addr300", 32'h300, 1'b1);
        tick(1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        wait_req("t6_addrFFC", 32'hFFFF_FFFC, 1'b1);
        ack_after_one(1'b1);
        chk("t6_ipcFFC", instr_pc_o, 32'hFFFF_FFFC);
        wait_req("t6_wrap0", 32'h0, 1'b1);
        chk("t6_err_held", misaligned_err_o, 32'h1);
        ack_after_one(1'b1);
        tick(0, 1'b0, 32'h0, 1'b1);
        chk("t6_fetch_noreq", imem_req_o, 32'h0);
        tick(0, 1'b1, 32'h400, 1'b1);
        chk("t6_oldpc_req", imem_addr_o, 32'h4);
        tick(1, 1'b0, 32'h0, 1'b1);
        chk("t6_squash", instr_valid_o, 32'h0);
        wait_req("t6_addr400", 32'h400, 1'b1);

        // Reset while a request is outstanding
        tick(0, 1'b0, 32'h0, 1'b1);
        chk("t6_wait_req", imem_req_o, 32'h1);
        do_reset();
        wait_req("t6_post_rst", 32'h0, 1'b1);

        // Randomized traffic against the stream model
        d0 = n_deliv;
        for (int i = 0; i < 3000; i++) begin
            rd  = ($urandom_range(0, 15) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) tgt[31:4] = '1;
            if ($urandom_range(0, 499) == 0) do_reset();
            else tick(2, rd, tgt, ($urandom_range(0, 9) < 7));
        end
        chk("rand_progress", {31'h0, (n_deliv - d0) > 100}, 32'h1);

        tick(0, 1'b0, 32'h0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
